dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS core. On a start command it latches a sweep configuration, then drives the core's frequency tuning word `K` and phase offset `P` through a linear sweep of fixed steps. Each frequency is held for a programmable dwell time. It supports single, repeating and (optionally) triangle sweeps, and sits between the register/control logic and the DDS phase accumulator.

## Interface
Parameters:
- `KW`, 32, tuning-word width (matches the DDS `K` input)
- `PW`, 11, phase-offset width (matches the DDS `P` input)
- `DW`, 16, dwell counter width

Ports:
- `clk`  in  1  system clock, same clock as the DDS core
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  sweep start request, sampled only in IDLE
- `abort`  in  1  stop request, sampled only while busy
- `mode`  in  2  sweep mode: 00 single, 01 repeat, 10 triangle, 11 reserved (treated as single)
- `f_start`  in  KW  first tuning word
- `f_stop`  in  KW  last tuning word, must satisfy `f_stop` ≥ `f_start`
- `f_step`  in  KW  increment per step, must be non-zero
- `dwell`  in  DW  hold time per frequency, in cycles minus 1
- `p_off`  in  PW  phase offset forwarded to the DDS
- `K_out`  out  KW  tuning word to the DDS `K` input
- `P_out`  out  PW  phase offset to the DDS `P` input
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse on normal completion (single mode only)
- `wrap`  out  1  one-cycle pulse each time a sweep end point is reached (repeat/triangle)
- `cfg_err`  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, DWELL, STEP.
- **Reset:** all outputs are 0, the state is IDLE, and the latched configuration is cleared.
- **IDLE + `start`:** validate the inputs.
  - If `f_step` == 0 or `f_stop` < `f_start`: pulse `cfg_err` and stay in IDLE.
  - Otherwise: latch `mode`, `f_start`, `f_stop`, `f_step`, `dwell` and `p_off`. Load `K_out`=`f_start` and `P_out`=`p_off`, set `busy`=1, load the dwell counter with `dwell`, set direction to up, and go to DWELL.
- **DWELL:** decrement the counter. When it reaches 0, go to STEP.
- **STEP, direction up:** compute a (KW+1)-bit sum `K_out`+`f_step`. Clamp it to `f_stop` if the sum is ≥ `f_stop` or the carry is set.
  - If `K_out` is already equal to `f_stop` (end point reached):
    - single: pulse `done`, set `busy`=0, go to IDLE, and hold `K_out`.
    - repeat: pulse `wrap`, load `K_out`=`f_start`, go to DWELL.
    - triangle: pulse `wrap`, set direction to down, load the clamped `K_out`−`f_step`, go to DWELL.
  - Otherwise: load the clamped sum and go to DWELL.
- **STEP, direction down:** compute the difference and clamp it to `f_start` on borrow or if it is ≤ `f_start`. If `K_out` is already equal to `f_start`, pulse `wrap`, set direction to up and load the clamped up-step.
- **Degenerate sweep:** if `f_start` == `f_stop` the end point is reached at the first STEP. A triangle sweep then stays on that value and pulses `wrap` each dwell period.
- **`abort` while busy:** on the next edge, go to IDLE with `busy`=0. `K_out` and `P_out` hold, and there is no `done` or `wrap` pulse. `abort` has priority over a STEP in the same cycle.
- **Ignored inputs:** `start` while busy and `abort` in IDLE are ignored. If `start` and `abort` are both asserted in IDLE, the start is accepted.
- **Input changes:** changing the configuration inputs mid-sweep has no effect until the next start.
- **Reset mid-sweep:** asserting `rst_n` low clears everything immediately and asynchronously.

## Timing
- Every output is registered.
- `start` accepted at edge n: `busy`=1 and `K_out`=`f_start` are visible after edge n.
- Each frequency value is held for exactly `dwell`+1 cycles. The DWELL→STEP transition and the K update happen at the same edge, so there are no extra cycles between values.
- `done`, `wrap` and `cfg_err` are high for exactly one cycle. `done` coincides with the first cycle of `busy`=0.
- A new `start` is accepted on the first cycle `busy`=0, i.e. the cycle in which `done` is high.
- The DDS sees a new `K` one cycle after `K_out` changes, because of its own input register.

## Configuration
- **Macro:** `DDS_SWEEP_TRIANGLE_EN`.
- **Defined:** mode 10 runs the triangle sweep described above.
- **Undefined:**
  - Mode 10 behaves as repeat (01).
  - The direction state and the down-step subtractor are not built.
  - The descending clamp logic is removed.

## Test plan
- **Single sweep:** `f_start`=100, `f_stop`=400, `f_step`=100, `dwell`=2, start at cycle 0.
  - `K_out` = 100, 200, 300, 400, each held 3 cycles (cycles 1–12).
  - `done` pulses at cycle 13, with `busy` low from cycle 13.
- **Clamp and overflow:**
  - `f_start`=0, `f_stop`=250, `f_step`=100 gives 0, 100, 200, 250, then `done`.
  - `f_start`=0xFFFFFF00, `f_stop`=0xFFFFFFFF, `f_step`=0x80 gives 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFFF with no wrap to 0.
- **Repeat and triangle:** `f_start`=10, `f_stop`=30, `f_step`=10, `dwell`=0.
  - Repeat gives 10, 20, 30, 10, 20, with `wrap` pulsing on each return to 10.
  - Triangle (macro defined) gives 10, 20, 30, 20, 10, 20, with `wrap` at both turn points.
  - Triangle with the macro undefined behaves as repeat.
- **Rejected start:** `f_step`=0, or `f_stop`=5 with `f_start`=9, produces a one-cycle `cfg_err`; `busy` stays 0 and `K_out` is unchanged.
- **Abort:** `abort` asserted in the middle of a dwell period gives `busy`=0 on the next cycle, `K_out` frozen, and no `done`. A `start` issued while busy is ignored and `K_out` is unaffected.
- **Reset mid-sweep:** `rst_n` pulled low mid-sweep clears `K_out`, `P_out`, `busy`, `done`, `wrap` and `cfg_err` to 0 immediately. After release, a fresh start behaves as in the single-sweep scenario.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Bus bundle between the sweep register/control logic and dds_sweep_ctrl.
//   master: drives start/abort and the sweep configuration, receives K/P and status
//   slave : the sweep sequencer itself
// Signals:
//   start, abort         sweep start / stop requests
//   mode[1:0]            00 single, 01 repeat, 10 triangle, 11 single
//   f_start/f_stop/f_step[KW-1:0]  sweep end points and increment
//   dwell[DW-1:0]        hold time per frequency, cycles minus 1
//   p_off[PW-1:0]        phase offset forwarded to the DDS
//   K_out[KW-1:0], P_out[PW-1:0]   tuning word / phase offset to the DDS
//   busy, done, wrap, cfg_err      status and one-cycle event pulses
interface dds_sweep_ctrl_if #(
  parameter int unsigned KW = 32,
  parameter int unsigned PW = 11,
  parameter int unsigned DW = 16
);
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [KW-1:0] f_start;
  logic [KW-1:0] f_stop;
  logic [KW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic [PW-1:0] p_off;
  logic [KW-1:0] K_out;
  logic [PW-1:0] P_out;
  logic          busy;
  logic          done;
  logic          wrap;
  logic          cfg_err;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell, p_off,
    input  K_out, P_out, busy, done, wrap, cfg_err
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell, p_off,
    output K_out, P_out, busy, done, wrap, cfg_err
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS core. A start latches the sweep
// configuration, then K_out steps linearly from f_start to f_stop by f_step,
// each value held dwell+1 cycles. Single, repeat and triangle modes.
// Ports:
//   clk    system clock (shared with the DDS core)
//   rst_n  asynchronous active-low reset
//   bus    dds_sweep_ctrl_if.slave: start/abort, configuration inputs,
//          K_out/P_out, busy, done/wrap/cfg_err pulses (all outputs registered)
// Build option:
//   DDS_SWEEP_TRIANGLE_EN  defined: mode 10 is a triangle sweep;
//                          undefined: mode 10 behaves as repeat and the
//                          down-count path is not built.
module dds_sweep_ctrl #(
  parameter int unsigned KW = 32,
  parameter int unsigned PW = 11,
  parameter int unsigned DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dds_sweep_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  state_t        r_state, w_state_n;
  logic [1:0]    r_mode;
  logic [KW-1:0] r_f_start, r_f_stop, r_f_step;
  logic [DW-1:0] r_dwell, r_cnt, w_cnt_n;
  logic [KW-1:0] r_k, w_k_n;
  logic [PW-1:0] r_p, w_p_n;
  logic          r_busy, w_busy_n;
  logic          r_done, w_done_n;
  logic          r_wrap, w_wrap_n;
  logic          r_err, w_err_n;
  logic          w_accept;
  logic          w_single;
  logic [KW:0]   w_sum;
  logic [KW-1:0] w_k_up;

  // Up-step with carry; clamps to f_stop so the sweep never wraps through 0.
  assign w_sum    = {1'b0, r_k} + {1'b0, r_f_step};
  assign w_k_up   = (w_sum[KW] || (w_sum[KW-1:0] >= r_f_stop)) ? r_f_stop : w_sum[KW-1:0];
  assign w_single = (r_mode == 2'b00) || (r_mode == 2'b11);

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic          r_dir_dn, w_dir_dn_n;
  logic          w_tri;
  logic [KW:0]   w_diff;
  logic [KW-1:0] w_k_dn;

  assign w_tri  = (r_mode == 2'b10);
  assign w_diff = {1'b0, r_k} - {1'b0, r_f_step};
  assign w_k_dn = (w_diff[KW] || (w_diff[KW-1:0] <= r_f_start)) ? r_f_start : w_diff[KW-1:0];
`endif

  // The STEP decision is taken in the last DWELL cycle (counter at 0) so the
  // new value appears on the same edge that ends the dwell: no gap cycle.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_k_n     = r_k;
    w_p_n     = r_p;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_wrap_n  = 1'b0;
    w_err_n   = 1'b0;
    w_accept  = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
    w_dir_dn_n = r_dir_dn;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if ((bus.f_step == '0) || (bus.f_stop < bus.f_start)) begin
            w_err_n = 1'b1;
          end else begin
            w_accept  = 1'b1;
            w_k_n     = bus.f_start;
            w_p_n     = bus.p_off;
            w_busy_n  = 1'b1;
            w_cnt_n   = bus.dwell;
            w_state_n = DWELL;
`ifdef DDS_SWEEP_TRIANGLE_EN
            w_dir_dn_n = 1'b0;
`endif
          end
        end
      end
      DWELL: begin
        if (bus.abort) begin
          w_state_n = IDLE;
          w_busy_n  = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_n = r_cnt - DW'(1);
        end else begin
          w_cnt_n = r_dwell;
`ifdef DDS_SWEEP_TRIANGLE_EN
          if (r_dir_dn) begin
            if (r_k == r_f_start) begin
              w_wrap_n   = 1'b1;
              w_dir_dn_n = 1'b0;
              w_k_n      = w_k_up;
            end else begin
              w_k_n = w_k_dn;
            end
          end else
`endif
          if (r_k == r_f_stop) begin
            if (w_single) begin
              w_done_n  = 1'b1;
              w_busy_n  = 1'b0;
              w_state_n = IDLE;
            end
`ifdef DDS_SWEEP_TRIANGLE_EN
            else if (w_tri) begin
              w_wrap_n   = 1'b1;
              w_dir_dn_n = 1'b1;
              w_k_n      = w_k_dn;
            end
`endif
            else begin
              w_wrap_n = 1'b1;
              w_k_n    = r_f_start;
            end
          end else begin
            w_k_n = w_k_up;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mode    <= '0;
      r_f_start <= '0;
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_dwell   <= '0;
      r_cnt     <= '0;
      r_k       <= '0;
      r_p       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
      r_dir_dn  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_k     <= w_k_n;
      r_p     <= w_p_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_wrap  <= w_wrap_n;
      r_err   <= w_err_n;
`ifdef DDS_SWEEP_TRIANGLE_EN
      r_dir_dn <= w_dir_dn_n;
`endif
      if (w_accept) begin
        r_mode    <= bus.mode;
        r_f_start <= bus.f_start;
        r_f_stop  <= bus.f_stop;
        r_f_step  <= bus.f_step;
        r_dwell   <= bus.dwell;
      end
    end
  end

  assign bus.K_out   = r_k;
  assign bus.P_out   = r_p;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.wrap    = r_wrap;
  assign bus.cfg_err = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl. Stimulus drives inputs on the falling edge and
// pushes the reference model's expected outputs for the next rising edge into
// a scoreboard queue; a monitor pops and compares shortly after each rising
// edge. The model precomputes each sweep as a per-cycle plan of values.
module tb_dds_sweep_ctrl;
  localparam int unsigned KW = 32;
  localparam int unsigned PW = 11;
  localparam int unsigned DW = 16;
  localparam int unsigned PLAN_CAP = 1200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.KW(KW), .PW(PW), .DW(DW)) bus ();

  dds_sweep_ctrl #(.KW(KW), .PW(PW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [KW-1:0] k;
    logic [PW-1:0] p;
    logic busy, done, wrap, err;
  } exp_t;

  typedef struct {
    logic [KW-1:0] k;
    logic busy, done, wrap;
  } plan_t;

  exp_t  sb[$];
  plan_t plan[$];
  exp_t  mon_e;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [KW-1:0] m_k;
  logic [PW-1:0] m_p;
  bit            m_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Expected sweep as a list of per-cycle outputs, from plain 64-bit arithmetic.
  task automatic build_plan(input logic [1:0] md, input logic [KW-1:0] fs, input logic [KW-1:0] fe,
                            input logic [KW-1:0] fst, input logic [DW-1:0] dw);
    longint unsigned v, s, e, st;
    bit up, w, single_m, tri_m;
    s = 64'(fs); e = 64'(fe); st = 64'(fst);
    v = s; up = 1'b1; w = 1'b0;
    single_m = (md == 2'b00) || (md == 2'b11);
`ifdef DDS_SWEEP_TRIANGLE_EN
    tri_m = (md == 2'b10);
`else
    tri_m = 1'b0;
`endif
    plan.delete();
    while (plan.size() < PLAN_CAP) begin
      for (int i = 0; i <= int'(dw); i++)
        plan.push_back('{k: KW'(v), busy: 1'b1, done: 1'b0, wrap: (i == 0) && w});
      w = 1'b0;
      if (up && v == e) begin
        if (single_m) begin
          plan.push_back('{k: KW'(v), busy: 1'b0, done: 1'b1, wrap: 1'b0});
          break;
        end
        w = 1'b1;
        if (tri_m) begin up = 1'b0; v = (v <= s + st) ? s : v - st; end
        else v = s;
      end else if (up) begin
        v = (v + st >= e) ? e : v + st;
      end else if (v == s) begin
        up = 1'b1; w = 1'b1;
        v = (v + st >= e) ? e : v + st;
      end else begin
        v = (v <= s + st) ? s : v - st;
      end
    end
  endtask

  task automatic model_step(input bit st, input bit ab, input logic [1:0] md, input logic [KW-1:0] fs,
                            input logic [KW-1:0] fe, input logic [KW-1:0] fst,
                            input logic [DW-1:0] dw, input logic [PW-1:0] po);
    exp_t x;
    plan_t pe;
    x.done = 1'b0; x.wrap = 1'b0; x.err = 1'b0;
    if (m_busy) begin
      if (ab) begin
        plan.delete();
        m_busy = 1'b0;
      end else if (plan.size() == 0) begin
        n_checks++;
        $display("FAIL model_plan: got empty plan, expected a pending entry at t=%0t", $time);
        m_busy = 1'b0;
      end else begin
        pe = plan.pop_front();
        m_k = pe.k; m_busy = pe.busy; x.done = pe.done; x.wrap = pe.wrap;
      end
    end else if (st) begin
      if (fst == '0 || fe < fs) begin
        x.err = 1'b1;
      end else begin
        build_plan(md, fs, fe, fst, dw);
        m_p = po;
        pe = plan.pop_front();
        m_k = pe.k; m_busy = pe.busy; x.done = pe.done; x.wrap = pe.wrap;
      end
    end
    x.k = m_k; x.p = m_p; x.busy = m_busy;
    sb.push_back(x);
  endtask

  task automatic drive(input bit st, input bit ab, input logic [1:0] md, input logic [KW-1:0] fs,
                       input logic [KW-1:0] fe, input logic [KW-1:0] fst,
                       input logic [DW-1:0] dw, input logic [PW-1:0] po);
    @(negedge clk);
    bus.start = st; bus.abort = ab; bus.mode = md;
    bus.f_start = fs; bus.f_stop = fe; bus.f_step = fst;
    bus.dwell = dw; bus.p_off = po;
    model_step(st, ab, md, fs, fe, fst, dw, po);
  endtask

  task automatic rand_cfg(output logic [1:0] md, output logic [KW-1:0] fs, output logic [KW-1:0] fe,
                          output logic [KW-1:0] fst, output logic [DW-1:0] dw, output logic [PW-1:0] po);
    longint unsigned e64;
    md = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) fs = KW'(32'hFFFF_FFFF - $urandom_range(0, 2000));
    else fs = KW'($urandom_range(0, 5000));
    e64 = 64'(fs) + 64'($urandom_range(0, 600));
    if (e64 > 64'hFFFF_FFFF) e64 = 64'hFFFF_FFFF;
    fe = KW'(e64);
    if ($urandom_range(0, 7) == 0 && fs != '0) fe = fs - KW'(1);
    fst = ($urandom_range(0, 9) == 0) ? '0 : KW'($urandom_range(25, 300));
    dw = DW'($urandom_range(0, 3));
    po = PW'($urandom());
  endtask

  // One cycle with randomised configuration inputs (ignored unless a start is accepted).
  task automatic cyc(input bit st, input bit ab);
    logic [1:0] md; logic [KW-1:0] fs, fe, fst; logic [DW-1:0] dw; logic [PW-1:0] po;
    rand_cfg(md, fs, fe, fst, dw, po);
    drive(st, ab, md, fs, fe, fst, dw, po);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic go(input int unsigned md, input logic [KW-1:0] fs, input logic [KW-1:0] fe,
                    input logic [KW-1:0] fst, input int unsigned dw, input int unsigned po);
    drive(1'b1, 1'b0, 2'(md), fs, fe, fst, DW'(dw), PW'(po));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_K"}, 64'(bus.K_out), 64'd0);
    check({tag, "_P"}, 64'(bus.P_out), 64'd0);
    check({tag, "_flags"}, 64'({bus.busy, bus.done, bus.wrap, bus.cfg_err}), 64'd0);
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 2 time units later.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("K_out", 64'(bus.K_out), 64'(mon_e.k));
        check("P_out", 64'(bus.P_out), 64'(mon_e.p));
        check("busy_done_wrap_err", 64'({bus.busy, bus.done, bus.wrap, bus.cfg_err}),
              64'({mon_e.busy, mon_e.done, mon_e.wrap, mon_e.err}));
      end
    end
  end

  initial begin
    int abort_at;
    logic [1:0] md; logic [KW-1:0] fs, fe, fst; logic [DW-1:0] dw; logic [PW-1:0] po;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = '0;
    bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0; bus.p_off = '0;
    m_k = '0; m_p = '0; m_busy = 1'b0;
    #1;
    check_cleared("reset");
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;

    // Single sweep 100..400 step 100, dwell 2
    go(0, 100, 400, 100, 2, 11'h155); run(16);
    // Clamp at top and near-overflow
    go(0, 0, 250, 100, 1, 3); run(12);
    go(0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 0, 7); run(6);
    // Repeat, triangle, degenerate triangle, reserved mode
    go(1, 10, 30, 10, 0, 1); run(12); cyc(1'b0, 1'b1); run(2);
    go(2, 10, 30, 10, 0, 2); run(14); cyc(1'b0, 1'b1); run(2);
    go(2, 50, 50, 7, 1, 3); run(8); cyc(1'b0, 1'b1); run(1);
    go(3, 5, 25, 10, 0, 4); run(6);
    // Rejected starts
    go(0, 9, 5, 1, 0, 9); run(2);
    go(0, 0, 100, 0, 1, 9); run(2);
    // Abort mid-dwell, start while busy ignored
    go(0, 1000, 5000, 1000, 5, 5); run(3);
    drive(1'b1, 1'b0, 2'd0, 32'd1, 32'd2, 32'd1, 16'd0, 11'd0); run(2);
    cyc(1'b0, 1'b1); run(3);
    // Start and abort together in IDLE: start wins
    drive(1'b1, 1'b1, 2'd0, 32'd20, 32'd60, 32'd20, 16'd1, 11'd6); run(12);

    // Reset mid-sweep (async), then a fresh single sweep
    go(1, 100, 400, 100, 2, 8); run(7);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    plan.delete(); m_k = '0; m_p = '0; m_busy = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    go(0, 100, 400, 100, 2, 11'h155); run(16);

    // Randomised sweeps
    for (int t = 0; t < 40; t++) begin
      rand_cfg(md, fs, fe, fst, dw, po);
      drive(1'b1, 1'b0, md, fs, fe, fst, dw, po);
      abort_at = ($urandom_range(0, 2) == 0) ? 1000 : int'($urandom_range(2, 80));
      for (int c = 0; c < 200 && m_busy; c++)
        cyc($urandom_range(0, 7) == 0, c == abort_at);
      if (m_busy) cyc(1'b0, 1'b1);
      for (int c = 0; c < int'($urandom_range(1, 3)); c++)
        cyc(1'b0, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #3;
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
